// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encodings and scoreboard entry layout for the hazard controller
package hazard_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
    typedef struct packed {
        logic       v;
        logic [2:0] rd;
    } sb_entry_t;
    localparam int SB_W = $bits(sb_entry_t);
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination shift register, matched against two decode sources
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CHECK = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic [SB_W-1:0] entry,
    input  logic [2:0]      rs,
    input  logic            rs_used,
    input  logic [2:0]      rt,
    input  logic            rt_used,
    output logic            match
);
    sb_entry_t sb [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
        end else if (!freeze) begin
            sb[0] <= sb_entry_t'(entry);
            for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
        end
    end

    // only the youngest CHECK entries can still be ahead of the regfile read
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < CHECK; i++)
            if (sb[i].v && ((rs_used && sb[i].rd == rs) || (rt_used && sb[i].rd == rt)))
                match = 1'b1;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/drain control for the forwarding-less pipeline
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int BYPASS_WB = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [2:0]       dec_rs,
    input  logic             dec_rs_used,
    input  logic [2:0]       dec_rt,
    input  logic             dec_rt_used,
    input  logic             dec_RegWrite,
    input  logic [2:0]       dec_Write_Register,
    input  logic             dec_Halt,
    input  logic             ex_redirect,
    input  logic             mem_stall,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_Flush,
    output logic             Flush,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int CHECK = BYPASS_WB != 0 ? DEPTH - 1 : DEPTH;
    localparam int DC_W  = $clog2(DEPTH + 1);

    state_t          state;
    logic [DC_W-1:0] drain_cnt;
    logic            match, raw, issue, halt_issue;
    logic [SB_W-1:0] sb_in;

    assign raw        = dec_valid && state == RUN && match;
    assign issue      = dec_valid && !ex_redirect && !raw && state == RUN;
    assign halt_issue = issue && dec_Halt;
    assign sb_in      = issue ? {dec_RegWrite, dec_Write_Register} : '0;

    hazard_scoreboard #(.DEPTH(DEPTH), .CHECK(CHECK)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .freeze  (mem_stall),
        .entry   (sb_in),
        .rs      (dec_rs),
        .rs_used (dec_rs_used),
        .rt      (dec_rt),
        .rt_used (dec_rt_used),
        .match   (match)
    );

    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_Flush = 1'b0;
        Flush       = 1'b0;
        pipe_freeze = 1'b0;
        halted      = !rst && state == HALTED;
        if (rst) begin
            halted = 1'b0;
        end else if (mem_stall) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            pipe_freeze = 1'b1;
        end else if (state != RUN) begin
            // redirects are ignored once HALT is in flight
            pc_stall    = 1'b1;
            if_id_Flush = 1'b1;
            Flush       = 1'b1;
            if_id_stall = state == HALTED;
        end else if (ex_redirect) begin
            if_id_Flush = 1'b1;
            Flush       = 1'b1;
        end else if (raw) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            Flush       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            drain_cnt    <= '0;
            stall_cycles <= '0;
        end else begin
            if (state == RUN && pc_stall && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
            if (!mem_stall) begin
                if (halt_issue) begin
                    state     <= DRAIN;
                    drain_cnt <= DC_W'(DEPTH);
                end else if (state == DRAIN) begin
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt == DC_W'(1)) state <= HALTED;
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of two hazard_ctrl builds (WB bypass on, and off with a 4-bit counter)
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dec_valid = 1'b0, dec_rs_used = 1'b0, dec_rt_used = 1'b0, dec_RegWrite = 1'b0;
    logic dec_Halt = 1'b0, ex_redirect = 1'b0, mem_stall = 1'b0;
    logic [2:0] dec_rs = '0, dec_rt = '0, dec_Write_Register = '0;
    logic [1:0] pc_stall, if_id_stall, if_id_Flush, Flush, pipe_freeze, halted;
    logic [15:0] sc0;
    logic [3:0]  sc1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl u0 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rs_used(dec_rs_used),
        .dec_rt(dec_rt), .dec_rt_used(dec_rt_used), .dec_RegWrite(dec_RegWrite),
        .dec_Write_Register(dec_Write_Register), .dec_Halt(dec_Halt), .ex_redirect(ex_redirect),
        .mem_stall(mem_stall), .pc_stall(pc_stall[0]), .if_id_stall(if_id_stall[0]),
        .if_id_Flush(if_id_Flush[0]), .Flush(Flush[0]), .pipe_freeze(pipe_freeze[0]),
        .halted(halted[0]), .stall_cycles(sc0)
    );

    hazard_ctrl #(.BYPASS_WB(0), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rs_used(dec_rs_used),
        .dec_rt(dec_rt), .dec_rt_used(dec_rt_used), .dec_RegWrite(dec_RegWrite),
        .dec_Write_Register(dec_Write_Register), .dec_Halt(dec_Halt), .ex_redirect(ex_redirect),
        .mem_stall(mem_stall), .pc_stall(pc_stall[1]), .if_id_stall(if_id_stall[1]),
        .if_id_Flush(if_id_Flush[1]), .Flush(Flush[1]), .pipe_freeze(pipe_freeze[1]),
        .halted(halted[1]), .stall_cycles(sc1)
    );

    // {pc_stall, if_id_stall, if_id_Flush, Flush, pipe_freeze, halted}
    function automatic logic [5:0] outs(input int i);
        return {pc_stall[i], if_id_stall[i], if_id_Flush[i], Flush[i], pipe_freeze[i], halted[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                         input logic rtu, input logic rw, input logic [2:0] wd, input logic halt,
                         input logic redir, input logic ms);
        @(posedge clk);
        #1;
        dec_valid = v; dec_rs = rs; dec_rs_used = rsu; dec_rt = rt; dec_rt_used = rtu;
        dec_RegWrite = rw; dec_Write_Register = wd; dec_Halt = halt;
        ex_redirect = redir; mem_stall = ms;
        #1;
    endtask

    task automatic nop();           drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic rd(input logic [2:0] r);  drive(1, r, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic wr(input logic [2:0] r);  drive(1, 0, 0, 0, 0, 1, r, 0, 0, 0); endtask

    task automatic do_rst();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_outs0", 32'(outs(0)), 32'h0);
        check("rst_outs1", 32'(outs(1)), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // 1: RAW on r3 right behind its producer
        do_rst();
        check("rst_sc0", 32'(sc0), 32'd0);
        wr(3);
        check("t1_issue0", 32'(outs(0)), 32'h0);
        rd(3);
        check("t1_c1_0", 32'(outs(0)), 32'b110100);
        check("t1_c1_1", 32'(outs(1)), 32'b110100);
        rd(3);
        check("t1_c2_0", 32'(outs(0)), 32'b110100);
        check("t1_c2_1", 32'(outs(1)), 32'b110100);
        rd(3);
        check("t1_c3_0", 32'(outs(0)), 32'h0);
        check("t1_c3_1", 32'(outs(1)), 32'b110100);
        rd(3);
        check("t1_c4_1", 32'(outs(1)), 32'h0);
        nop();
        check("t1_sc0", 32'(sc0), 32'd2);
        check("t1_sc1", 32'(sc1), 32'd3);

        // 2: redirect beats RAW; the squashed r5 writer must not enter the scoreboard
        do_rst();
        wr(3);
        drive(1, 3, 1, 0, 0, 1, 5, 0, 1, 0);
        check("t2_redir0", 32'(outs(0)), 32'b001100);
        check("t2_redir1", 32'(outs(1)), 32'b001100);
        rd(5);
        check("t2_sb0_0", 32'(outs(0)), 32'h0);
        check("t2_sb0_1", 32'(outs(1)), 32'h0);

        // 3: memory freeze in the middle of a RAW stall
        do_rst();
        wr(3);
        rd(3);
        check("t3_raw0", 32'(outs(0)), 32'b110100);
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
            check("t3_frz0", 32'(outs(0)), 32'b110010);
            check("t3_frz1", 32'(outs(1)), 32'b110010);
        end
        rd(3);
        check("t3_rel0", 32'(outs(0)), 32'b110100);
        check("t3_rel1", 32'(outs(1)), 32'b110100);
        rd(3);
        check("t3_end0", 32'(outs(0)), 32'h0);
        check("t3_rem1", 32'(outs(1)), 32'b110100);
        rd(3);
        check("t3_end1", 32'(outs(1)), 32'h0);
        nop();
        check("t3_sc0", 32'(sc0), 32'd6);
        check("t3_sc1", 32'(sc1), 32'd7);

        // 4: HALT with an empty pipe, redirect ignored while draining, freeze while halted
        do_rst();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("t4_halt0", 32'(outs(0)), 32'h0);
        nop();
        check("t4_drain1_0", 32'(outs(0)), 32'b101100);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("t4_drain2_0", 32'(outs(0)), 32'b101100);
        nop();
        check("t4_drain3_0", 32'(outs(0)), 32'b101100);
        check("t4_drain3_1", 32'(outs(1)), 32'b101100);
        for (int i = 0; i < 10; i++) begin
            nop();
            check("t4_halted0", 32'(outs(0)), 32'b111101);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("t4_hfrz0", 32'(outs(0)), 32'b110011);
        nop();
        check("t4_hafter0", 32'(outs(0)), 32'b111101);
        check("t4_sc0", 32'(sc0), 32'd0);

        // 5: reset while draining with drain_cnt=2
        do_rst();
        wr(3);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        nop();
        check("t5_drain0", 32'(outs(0)), 32'b101100);
        do_rst();
        check("t5_run0", 32'(outs(0)), 32'h0);
        check("t5_run1", 32'(outs(1)), 32'h0);
        check("t5_sc0", 32'(sc0), 32'd0);
        rd(3);
        check("t5_sb0", 32'(outs(0)), 32'h0);
        check("t5_sb1", 32'(outs(1)), 32'h0);

        // 6: counter saturation (4-bit build saturates, 16-bit build keeps counting)
        do_rst();
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        nop();
        check("t6_sc0", 32'(sc0), 32'd20);
        check("t6_sat1", 32'(sc1), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
